uart_cmd_wrapper: RTL

UART_CMD_WRAPPER -- requirements
Module: uart_cmd_wrapper

---
 rtl/uart_cmd_pkg.sv | 21 ++
 rtl/uart_cmd_wrapper_uart.sv | 175 +++++++++++++++++
 rtl/uart_cmd_wrapper.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared types and defaults for the UART command wrapper.
// Holds the assembler/UART state enums and default timing constants.
package uart_cmd_pkg;

    localparam int DEF_BAUD_DIV    = 434;
    localparam int DEF_TIMEOUT_CYC = 1_000_000;
    localparam int FRAME_BITS      = 10;

    typedef enum logic {
        WAIT_HI = 1'b0,
        WAIT_LO = 1'b1
    } asm_state_t;

    typedef enum logic [1:0] {
        U_IDLE  = 2'd0,
        U_START = 2'd1,
        U_DATA  = 2'd2,
        U_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_cmd_wrapper_uart.sv
// Byte-level 8N1 UART: receiver and transmitter running side by side.
// Ports: clk, rst_n (async, active low), i_rx serial in, o_rx_rdy/o_rx_data
//   one-cycle received-byte strobe and data, i_trmt/i_tx_data start a frame,
//   o_tx serial out, o_tx_busy frame in flight, o_tx_done last stop cycle.
module uart_cmd_wrapper_uart
    import uart_cmd_pkg::*;
#(
    parameter int BAUD_DIV = DEF_BAUD_DIV
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rx,
    output logic       o_rx_rdy,
    output logic [7:0] o_rx_data,
    input  logic       i_trmt,
    input  logic [7:0] i_tx_data,
    output logic       o_tx,
    output logic       o_tx_busy,
    output logic       o_tx_done
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] C_HALF = CW'(BAUD_DIV / 2 - 1);
    localparam logic [3:0]    B_LAST = 4'(FRAME_BITS - 1);

    // ---------------- receiver ----------------
    logic          r_rx_meta;
    logic          r_rx_sync;
    logic          r_rx_prev;
    uart_state_t   r_rx_state;
    uart_state_t   w_rx_state_nxt;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_shift;
    logic          r_rx_rdy;
    logic          w_rx_fall;
    logic          w_rx_sample;
    logic          w_rx_good;
    logic          w_rx_restart;

    assign w_rx_fall = r_rx_prev & ~r_rx_sync;

    // Line idles high, so the synchronizer resets to 1 to avoid
    // a false start edge straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_state <= U_IDLE;
        end else begin
            r_rx_state <= w_rx_state_nxt;
        end
    end

    // START waits half a bit so every later sample lands mid-bit;
    // a start bit that has gone high again by then is a glitch.
    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_sample    = 1'b0;
        w_rx_good      = 1'b0;
        unique case (r_rx_state)
            U_IDLE: begin
                if (w_rx_fall) begin
                    w_rx_state_nxt = U_START;
                end
            end
            U_START: begin
                if (r_rx_cnt == C_HALF) begin
                    w_rx_state_nxt = r_rx_sync ? U_IDLE : U_DATA;
                end
            end
            U_DATA: begin
                if (r_rx_cnt == C_LAST) begin
                    w_rx_sample = 1'b1;
                    if (r_rx_bit == 3'd7) begin
                        w_rx_state_nxt = U_STOP;
                    end
                end
            end
            U_STOP: begin
                if (r_rx_cnt == C_LAST) begin
                    w_rx_state_nxt = U_IDLE;
                    w_rx_good      = r_rx_sync;
                end
            end
            default: begin
                w_rx_state_nxt = U_IDLE;
            end
        endcase
    end

    assign w_rx_restart = (r_rx_state == U_IDLE)
                        || (w_rx_state_nxt != r_rx_state)
                        || w_rx_sample;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_rdy   <= 1'b0;
        end else begin
            r_rx_rdy <= w_rx_good;
            if (w_rx_restart) begin
                r_rx_cnt <= '0;
            end else begin
                r_rx_cnt <= r_rx_cnt + 1'b1;
            end
            // LSB arrives first: shift in from the top.
            if (w_rx_sample) begin
                r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                r_rx_bit   <= r_rx_bit + 1'b1;
            end
        end
    end

    assign o_rx_rdy  = r_rx_rdy;
    assign o_rx_data = r_rx_shift;

    // ---------------- transmitter ----------------
    logic [9:0]    r_tx_shift;
    logic          r_tx_busy;
    logic [CW-1:0] r_tx_cnt;
    logic [3:0]    r_tx_bit;
    logic          w_tx_tick;
    logic          w_tx_done;

    assign w_tx_tick = r_tx_busy && (r_tx_cnt == C_LAST);
    assign w_tx_done = w_tx_tick && (r_tx_bit == B_LAST);

    // The line is bit 0 of a 1-filled shift register, so reset
    // drives it high asynchronously and it idles high after a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_shift <= '1;
            r_tx_busy  <= 1'b0;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
        end else if (!r_tx_busy) begin
            if (i_trmt) begin
                r_tx_shift <= {1'b1, i_tx_data, 1'b0};
                r_tx_busy  <= 1'b1;
                r_tx_cnt   <= '0;
                r_tx_bit   <= '0;
            end
        end else if (w_tx_tick) begin
            r_tx_cnt   <= '0;
            r_tx_shift <= {1'b1, r_tx_shift[9:1]};
            if (w_tx_done) begin
                r_tx_busy <= 1'b0;
                r_tx_bit  <= '0;
            end else begin
                r_tx_bit <= r_tx_bit + 1'b1;
            end
        end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
        end
    end

    assign o_tx      = r_tx_shift[0];
    assign o_tx_busy = r_tx_busy;
    assign o_tx_done = w_tx_done;

endmodule

// File: rtl/uart_cmd_wrapper.sv
// Assembles two UART bytes into a 16-bit command and sends response bytes.
// Ports: clk, rst_n (async, active low), RX/TX serial link (idle high),
//   cmd/cmd_rdy assembled command + level flag, clr_cmd_rdy acknowledge,
//   resp/send_resp response byte + start strobe, resp_sent frame-done level.
// Build option: define CMD_TIMEOUT_EN to drop a lone first byte after
//   TIMEOUT_CYC idle cycles; without it WAIT_LO waits forever.
module uart_cmd_wrapper
    import uart_cmd_pkg::*;
#(
    parameter int BAUD_DIV    = DEF_BAUD_DIV,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        resp_sent
);

    logic       w_rx_rdy;
    logic [7:0] w_rx_data;
    logic       w_trmt;
    logic       w_tx;
    logic       w_tx_busy;
    logic       w_tx_done;
    logic       w_timeout;

    asm_state_t  r_state;
    asm_state_t  w_state_nxt;
    logic        w_load_hi;
    logic        w_load_cmd;
    logic [7:0]  r_staged;
    logic [15:0] r_cmd;
    logic        r_cmd_rdy;
    logic        r_resp_sent;

    // A strobe while a frame is in flight is simply not accepted.
    assign w_trmt = send_resp & ~w_tx_busy;

    uart_cmd_wrapper_uart #(
        .BAUD_DIV (BAUD_DIV)
    ) u_uart (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_rx      (RX),
        .o_rx_rdy  (w_rx_rdy),
        .o_rx_data (w_rx_data),
        .i_trmt    (w_trmt),
        .i_tx_data (resp),
        .o_tx      (w_tx),
        .o_tx_busy (w_tx_busy),
        .o_tx_done (w_tx_done)
    );

`ifdef CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] r_to_cnt;

    assign w_timeout = (r_state == WAIT_LO)
                     && (r_to_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if ((r_state != WAIT_LO) || w_rx_rdy || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end
`else
    logic w_unused_timeout;
    assign w_unused_timeout = |TIMEOUT_CYC;
    assign w_timeout        = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= WAIT_HI;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load_hi   = 1'b0;
        w_load_cmd  = 1'b0;
        unique case (r_state)
            WAIT_HI: begin
                if (w_rx_rdy) begin
                    w_load_hi   = 1'b1;
                    w_state_nxt = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (w_rx_rdy) begin
                    w_load_cmd  = 1'b1;
                    w_state_nxt = WAIT_HI;
                end else if (w_timeout) begin
                    w_state_nxt = WAIT_HI;
                end
            end
            default: begin
                w_state_nxt = WAIT_HI;
            end
        endcase
    end

    // cmd only changes on a complete pair, so it stays stable while a
    // new first byte sits in the staging register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_staged  <= '0;
            r_cmd     <= '0;
            r_cmd_rdy <= 1'b0;
        end else begin
            if (w_load_hi) begin
                r_staged <= w_rx_data;
            end
            if (w_load_cmd) begin
                r_cmd <= {r_staged, w_rx_data};
            end
            // Set has priority over the consumer's clear.
            if (w_load_cmd) begin
                r_cmd_rdy <= 1'b1;
            end else if (clr_cmd_rdy || w_load_hi) begin
                r_cmd_rdy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_sent <= 1'b0;
        end else if (w_tx_done) begin
            r_resp_sent <= 1'b1;
        end else if (w_trmt) begin
            r_resp_sent <= 1'b0;
        end
    end

    assign TX        = w_tx;
    assign cmd       = r_cmd;
    assign cmd_rdy   = r_cmd_rdy;
    assign resp_sent = r_resp_sent;

endmodule
